fpu_mul_scheduler: RTL

Round-robin scheduler that shares one single-precision `multiplication` datapath among `NUM_REQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and holds the operands stable on the multiplier inputs for `MUL_LAT` cycles. It then samples the product and exception flags and returns them, tagged with the requester index, over a single valid/ready response port. It also keeps per-requester sticky overflow/underflow flags for the FPU status logic.

---
 rtl/fpu_mul_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul_scheduler.sv
// Round-robin scheduler sharing one single-precision multiplier among NUM_REQ requesters.
// Operands are held for MUL_LAT cycles, then the product and flags are returned with the requester id.
module fpu_mul_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_data1,
    input  logic [NUM_REQ*32-1:0] req_data2,
    output logic [31:0]           mul_data1,
    output logic [31:0]           mul_data2,
    input  logic [31:0]           mul_result,
    input  logic                  mul_overflow,
    input  logic                  mul_underflow,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [31:0]           resp_result,
    output logic                  resp_overflow,
    output logic                  resp_underflow,
    output logic [NUM_REQ-1:0]    flag_overflow,
    output logic [NUM_REQ-1:0]    flag_underflow,
    input  logic [NUM_REQ-1:0]    flag_clear,
    output logic                  busy
);

    localparam int CW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [31:0]          op1_q, op1_d;
    logic [31:0]          op2_q, op2_d;
    logic [31:0]          res_q, res_d;
    logic                 rovf_q, rovf_d;
    logic                 runf_q, runf_d;
    logic [NUM_REQ-1:0]   fovf_q, fovf_d;
    logic [NUM_REQ-1:0]   funf_q, funf_d;

    logic                 gnt_found_s;
    logic [IDW-1:0]       gnt_idx_s;
    logic                 hs_s;
    logic                 done_s;
    logic [NUM_REQ-1:0]   id_mask_s;
    logic [NUM_REQ-1:0]   set_ovf_s;
    logic [NUM_REQ-1:0]   set_unf_s;

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin : arb
        int scan;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        scan        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_found_s && req_valid[scan]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = IDW'(scan);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign hs_s      = (state_q == IDLE) && gnt_found_s && !rst;
    assign done_s    = (state_q == EXEC) && (cnt_q == CW'(MUL_LAT - 1));
    assign id_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
    assign set_ovf_s = (done_s && mul_overflow)  ? id_mask_s : {NUM_REQ{1'b0}};
    assign set_unf_s = (done_s && mul_underflow) ? id_mask_s : {NUM_REQ{1'b0}};

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (done_s) begin
                    state_d = RESP;
                end else begin
                    state_d = EXEC;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, id, counter, response and sticky-flag updates.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        id_d   = id_q;
        op1_d  = op1_q;
        op2_d  = op2_q;
        res_d  = res_q;
        rovf_d = rovf_q;
        runf_d = runf_q;
        if (hs_s) begin
            op1_d = req_data1[int'(gnt_idx_s)*32 +: 32];
            op2_d = req_data2[int'(gnt_idx_s)*32 +: 32];
            id_d  = gnt_idx_s;
            cnt_d = '0;
            if (int'(gnt_idx_s) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + IDW'(1);
            end
        end else if (state_q == EXEC) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        if (done_s) begin
            res_d  = mul_result;
            rovf_d = mul_overflow;
            runf_d = mul_underflow;
        end else begin
            res_d  = res_q;
        end
        // Set has priority over a coincident clear.
        fovf_d = (fovf_q & ~flag_clear) | set_ovf_s;
        funf_d = (funf_q & ~flag_clear) | set_unf_s;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            op1_q   <= 32'h0000_0000;
            op2_q   <= 32'h0000_0000;
            res_q   <= 32'h0000_0000;
            rovf_q  <= 1'b0;
            runf_q  <= 1'b0;
            fovf_q  <= '0;
            funf_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            rovf_q  <= rovf_d;
            runf_q  <= runf_d;
            fovf_q  <= fovf_d;
            funf_q  <= funf_d;
        end
    end

    // Outputs decoded from state and registers.
    always_comb begin
        if ((state_q == IDLE) && gnt_found_s && !rst) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
        end else begin
            req_ready = '0;
        end
        resp_valid     = (state_q == RESP);
        busy           = (state_q != IDLE);
        mul_data1      = op1_q;
        mul_data2      = op2_q;
        resp_id        = id_q;
        resp_result    = res_q;
        resp_overflow  = rovf_q;
        resp_underflow = runf_q;
        flag_overflow  = fovf_q;
        flag_underflow = funf_q;
    end

endmodule
